// File: rtl/mem_alu_pipe.sv
// rtl/mem_alu_pipe.sv - two-read register file with pipelined ALU, write-back and bypass
module mem_alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [WIDTH-1:0]  init_data,
  output logic              out_valid,
  output logic [WIDTH-1:0]  result,
  output logic              flag,
  output logic              zero
);
  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              s1_valid;
  logic [2:0]        s1_op;
  logic              s1_wb_en;
  logic [ADDR_W-1:0] s1_wb_addr;
  logic [WIDTH-1:0]  s1_a;
  logic [WIDTH-1:0]  s1_b;

  logic [WIDTH-1:0]  alu_val;
  logic              alu_flag;
  logic              wb_live;
  logic [WIDTH-1:0]  opnd_a;
  logic [WIDTH-1:0]  opnd_b;

  // ALU evaluated on the stage-1 operands; also the bypass source
  always_comb begin
    alu_val  = '0;
    alu_flag = 1'b0;
    case (s1_op)
      3'd0: {alu_flag, alu_val} = {1'b0, s1_a} + {1'b0, s1_b};
      3'd1: begin
        alu_val  = s1_a - s1_b;
        alu_flag = (s1_a < s1_b);
      end
      3'd2: alu_val = s1_a & s1_b;
      3'd3: alu_val = s1_a | s1_b;
      3'd4: alu_val = s1_a ^ s1_b;
      3'd5: alu_val = (s1_a > s1_b) ? s1_a : s1_b;
      3'd6: alu_val = (s1_a < s1_b) ? s1_a : s1_b;
      default: alu_val = s1_a;
    endcase
  end

  // Operand select: a pending write-back to the same address overrides the stale file entry
  always_comb begin
    wb_live = s1_valid & s1_wb_en;
    opnd_a  = (wb_live && (s1_wb_addr == addr1)) ? alu_val : mem[addr1];
    opnd_b  = (wb_live && (s1_wb_addr == addr2)) ? alu_val : mem[addr2];
  end

  // Stage 1: capture the request and its operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= '0;
      s1_wb_en   <= 1'b0;
      s1_wb_addr <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op      <= op;
        s1_wb_en   <= wb_en;
        s1_wb_addr <= wb_addr;
        s1_a       <= opnd_a;
        s1_b       <= opnd_b;
      end
    end
  end

  // Stage 2: register the ALU result; outputs hold while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag      <= 1'b0;
      zero      <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= alu_val;
        flag   <= alu_flag;
        zero   <= (alu_val == '0);
      end
    end
  end

  // Register file: host write first so a same-edge write-back to the same entry wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (init_we) begin
        mem[init_addr] <= init_data;
      end
      if (wb_live) begin
        mem[s1_wb_addr] <= alu_val;
      end
    end
  end
endmodule

// File: tb/tb_mem_alu_pipe.sv
// tb/tb_mem_alu_pipe.sv - self-checking bench for mem_alu_pipe
module tb_mem_alu_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] op = '0;
  logic [3:0] addr1 = '0, addr2 = '0, wb_addr = '0, init_addr = '0;
  logic       wb_en = 1'b0, init_we = 1'b0;
  logic [7:0] init_data = '0;
  logic       out_valid, flag, zero;
  logic [7:0] result;

  int vectors = 0;
  int miscompares = 0;

  mem_alu_pipe #(.WIDTH(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op),
    .addr1(addr1), .addr2(addr2), .wb_en(wb_en), .wb_addr(wb_addr),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .out_valid(out_valid), .result(result), .flag(flag), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: a plain array for the file plus the one op whose result is still in flight
  logic [7:0] m_file [16];
  logic       p_valid, p_wb, p_flag;
  logic [3:0] p_addr;
  logic [7:0] p_res;
  logic       e_valid, e_flag, e_zero;
  logic [7:0] e_res;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a1;
    logic [3:0] a2;
    logic [7:0] res;
    logic       flg;
  } vec_t;
  vec_t vecs [8];

  function automatic void ref_alu(input logic [2:0] o, input int a, input int b,
                                  output logic [7:0] r, output logic f);
    int v;
    f = 1'b0;
    case (o)
      3'd0: begin v = a + b; f = (v > 255); end
      3'd1: begin v = a - b; f = (a < b); if (v < 0) v += 256; end
      3'd2: v = a & b;
      3'd3: v = a | b;
      3'd4: v = a ^ b;
      3'd5: v = (a > b) ? a : b;
      3'd6: v = (a < b) ? a : b;
      default: v = a;
    endcase
    r = v[7:0];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) m_file[i] = '0;
    p_valid = 0; p_wb = 0; p_addr = '0; p_res = '0; p_flag = 0;
    e_valid = 0; e_res = '0; e_flag = 0; e_zero = 0;
  endfunction

  function automatic void model_edge();
    logic [7:0] nr;
    logic       nf;
    nr = '0; nf = 0;
    if (p_valid && p_wb) m_file[p_addr] = p_res;
    if (in_valid) ref_alu(op, int'(m_file[addr1]), int'(m_file[addr2]), nr, nf);
    if (init_we && !(p_valid && p_wb && p_addr == init_addr)) m_file[init_addr] = init_data;
    e_valid = p_valid;
    if (p_valid) begin
      e_res = p_res; e_flag = p_flag; e_zero = (p_res == 0);
    end
    p_valid = in_valid; p_wb = wb_en; p_addr = wb_addr; p_res = nr; p_flag = nf;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    chk("out_valid", int'(out_valid), int'(e_valid));
    chk("result", int'(result), int'(e_res));
    chk("flag", int'(flag), int'(e_flag));
    chk("zero", int'(zero), int'(e_zero));
  endtask

  task automatic set_op(input logic [2:0] o, input logic [3:0] a1, input logic [3:0] a2,
                        input logic w, input logic [3:0] wa);
    in_valid = 1; op = o; addr1 = a1; addr2 = a2; wb_en = w; wb_addr = wa;
  endtask

  task automatic quiet();
    in_valid = 0; wb_en = 0; init_we = 0;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    quiet(); init_we = 1; init_addr = a; init_data = d;
    tick();
    init_we = 0;
  endtask

  task automatic read_entry(input string name, input logic [3:0] a, input logic [7:0] exp);
    set_op(3'd7, a, a, 0, 0);
    tick();
    quiet();
    tick();
    chk(name, int'(result), int'(exp));
  endtask

  initial begin
    model_clear();
    vecs[0] = '{3'd0, 4'd0, 4'd7, 8'h10, 1'b1};
    vecs[1] = '{3'd1, 4'd7, 4'd0, 8'h30, 1'b1};
    vecs[2] = '{3'd2, 4'd0, 4'd7, 8'h20, 1'b0};
    vecs[3] = '{3'd3, 4'd0, 4'd7, 8'hF0, 1'b0};
    vecs[4] = '{3'd4, 4'd0, 4'd7, 8'hD0, 1'b0};
    vecs[5] = '{3'd5, 4'd0, 4'd7, 8'hF0, 1'b0};
    vecs[6] = '{3'd6, 4'd0, 4'd7, 8'h20, 1'b0};
    vecs[7] = '{3'd7, 4'd0, 4'd7, 8'hF0, 1'b0};

    // Reset state
    #1;
    tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_zero", int'(zero), 0);
    rst_n = 1;

    // Basic ops with two-cycle latency
    host_write(4'd0, 8'hF0);
    host_write(4'd7, 8'h20);
    for (int i = 0; i < 8; i++) begin
      set_op(vecs[i].op, vecs[i].a1, vecs[i].a2, 0, 0);
      tick();
      chk("lat_not_early", int'(out_valid), 0);
      quiet();
      tick();
      chk("tbl_valid", int'(out_valid), 1);
      chk("tbl_result", int'(result), int'(vecs[i].res));
      chk("tbl_flag", int'(flag), int'(vecs[i].flg));
    end

    // Bypass chain: four dependent adds on consecutive cycles
    host_write(4'd1, 8'h01);
    for (int i = 0; i < 4; i++) begin
      set_op(3'd0, 4'd1, 4'd1, 1, 4'd1);
      tick();
      if (i > 0) chk("chain", int'(result), 1 << i);
    end
    quiet();
    tick();
    chk("chain_last", int'(result), 16);
    read_entry("chain_file", 4'd1, 8'd16);

    // Partial bypass: only operand A depends on the producer
    host_write(4'd2, 8'h05);
    host_write(4'd3, 8'h09);
    set_op(3'd0, 4'd2, 4'd3, 1, 4'd3);
    tick();
    set_op(3'd1, 4'd3, 4'd2, 0, 0);
    tick();
    quiet();
    tick();
    chk("partial_res", int'(result), 8'h09);
    chk("partial_flag", int'(flag), 0);

    // Write-back and host write to the same entry on the same edge
    host_write(4'd8, 8'h11);
    set_op(3'd7, 4'd8, 4'd8, 1, 4'd4);
    tick();
    quiet(); init_we = 1; init_addr = 4'd4; init_data = 8'hAA;
    tick();
    init_we = 0;
    read_entry("wb_wins", 4'd4, 8'h11);

    // Read of an entry being host-written returns the old value
    host_write(4'd5, 8'h33);
    set_op(3'd7, 4'd5, 4'd5, 0, 0);
    init_we = 1; init_addr = 4'd5; init_data = 8'h44;
    tick();
    quiet();
    tick();
    chk("init_old", int'(result), 8'h33);
    read_entry("init_new", 4'd5, 8'h44);

    // Zero result, then idle cycles hold the outputs
    host_write(4'd6, 8'h5A);
    set_op(3'd1, 4'd6, 4'd6, 0, 0);
    tick();
    quiet();
    tick();
    chk("zero_res", int'(result), 0);
    chk("zero_z", int'(zero), 1);
    chk("zero_flag", int'(flag), 0);
    tick();
    tick();
    chk("idle_valid", int'(out_valid), 0);
    chk("idle_hold", int'(result), 0);
    chk("idle_zero", int'(zero), 1);

    // Randomised traffic over a small address range to stress bypass and conflicts
    for (int n = 0; n < 400; n++) begin
      set_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)));
      in_valid  = ($urandom_range(0, 3) != 0);
      init_we   = ($urandom_range(0, 3) == 0);
      init_addr = 4'($urandom_range(0, 3));
      init_data = 8'($urandom);
      tick();
    end
    quiet();
    tick();
    tick();

    // Reset asserted with ops in flight discards them
    host_write(4'd9, 8'h07);
    set_op(3'd0, 4'd9, 4'd9, 1, 4'd9);
    tick();
    tick();
    rst_n = 0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_result", int'(result), 0);
    chk("arst_zero", int'(zero), 0);
    model_clear();
    quiet();
    tick();
    rst_n = 1;
    read_entry("arst_file9", 4'd9, 8'h00);
    read_entry("arst_file0", 4'd0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_alu_pipe.md
# mem_alu_pipe

Parametrised successor to the two-address memory/compute unit. It holds a DEPTH x WIDTH register file and accepts one operation per cycle that reads two entries (addr1, addr2). It applies a selectable ALU operation and returns the result after a fixed two-cycle latency. It can optionally write the result back into the file, with read-after-write bypass so that back-to-back dependent operations are correct. It sits between the host/test sequencer and the datapath as the next-generation compute core.

## Interface
- WIDTH, 8, data width of entries and result
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request this cycle
- op  input  3  operation select (see Operation)
- addr1  input  ADDR_W  operand A address
- addr2  input  ADDR_W  operand B address
- wb_en  input  1  write result back to wb_addr
- wb_addr  input  ADDR_W  write-back address
- init_we  input  1  direct host write enable
- init_addr  input  ADDR_W  host write address
- init_data  input  WIDTH  host write data
- out_valid  output  1  result valid
- result  output  WIDTH  operation result
- flag  output  1  carry (add) / borrow (sub), else 0
- zero  output  1  result == 0

## Operation
- Reset (rst_n low, asynchronous): all file entries, stage-1 registers, result, flag, zero and out_valid are cleared to 0. zero resets to 0, not 1. A reset asserted mid-operation discards all in-flight operations; no write-back occurs.
- Ops (unsigned): 0 add A+B, flag = carry-out. 1 sub A-B mod 2^WIDTH, flag = borrow (A<B). 2 and. 3 or. 4 xor. 5 max(A,B). 6 min(A,B). 7 pass A. flag = 0 for ops 2-7.
- Stage 1 (edge E0 with in_valid=1): capture op, wb_en, wb_addr and operands A=file[addr1], B=file[addr2] after bypass; set s1_valid.
- Stage 2 (edge E1): compute from stage-1 registers. Register result/flag/zero and set out_valid=1. If s1 wb_en=1, write file[s1 wb_addr] <= ALU value at the same edge.
- Bypass: when stage 1 holds a valid operation with wb_en=1 and its wb_addr equals addr1 (or addr2), the corresponding operand takes the current ALU output instead of the file. This applies to each operand independently, and to both operands when addr1==addr2==wb_addr.
- Host write: init_we writes init_data to init_addr at the clock edge. It is permitted at any time, including while in_valid is high.
- Simultaneous pipeline write-back and init write to the same address: write-back wins. Different addresses: both take effect.
- An operand read of an address being host-written in the same cycle returns the old value. Init writes are not bypassed.
- in_valid=0: no stage-1 capture. out_valid drops the cycle after s1_valid was 0. result/flag/zero hold their last values while out_valid=0.
- No backpressure: one operation is accepted per cycle, unconditionally.

## Timing
- Latency: in_valid sampled at edge E0 gives out_valid/result valid after edge E1, i.e. 2 cycles from request presentation to output register.
- Throughput: 1 op/cycle. A dependent op issued the cycle immediately after its producer sees the produced value via bypass. An op issued 2 or more cycles later reads it from the file.
- Write-back is visible in the file after E1.
- Reset is asynchronous on assertion. Deassertion is taken synchronously by the environment. The first request is valid on the first edge after rst_n high.
- Address wrap: addresses are ADDR_W bits, so there is no out-of-range case. Arithmetic wraps modulo 2^WIDTH, with the overflow reported only through flag.

## Test plan
- Reset/init: pulse rst_n low mid-stream with ops in flight. Then out_valid=0, result=0, zero=0, file reads return 0. No write-back lands.
- Basic ops, WIDTH=8: init file[0]=0xF0 and file[7]=0x20. Then add 0,7 gives 0x10 with flag=1. sub 7,0 gives 0x30 with flag=1. xor gives 0xD0. max gives 0xF0. min gives 0x20. pass gives 0xF0. Each result appears 2 cycles after its request.
- Bypass chain: file[1]=1. Issue add 1,1 with wb to 1 on four consecutive cycles. Results are 2, 4, 8, 16 on consecutive cycles, and file[1]=16 afterwards.
- Partial bypass: file[2]=5, file[3]=9. Issue add 2,3 with wb to 3, then next cycle sub 3,2. The second op gives 0x0E-0x05=0x09 with flag=0.
- Write conflict: in one cycle, write-back to 4 (value 0x11) and init_we to 4 with data 0xAA. Then file[4]=0x11. Same-cycle init to 5 and read of 5 returns the old value.
- zero/flag: sub 6,6 gives result 0, zero=1, flag=0. Idle cycles leave out_valid=0 and result held.
